if_prefetch_unit: RTL and testbench

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

---
 rtl/if_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/if_prefetch_unit.sv | 118 +++++++++++
 tb/tb_if_prefetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Brief    : Shared types and constants for the instruction prefetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_FETCH      = 2'd1,
        ST_DRAIN      = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two instruction queue with push/pop/flush and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    fetch_entry_t       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && ((r_count != c_cnt_w'(DEPTH)) || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_unit
// Brief    : Credit-based instruction prefetcher with redirect flush/drain.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned c_cnt_w  = $clog2(DEPTH + 1);
    localparam int unsigned c_sum_w  = c_cnt_w + 1;
    // Stale responses can outlive several redirects, so keep headroom past DEPTH.
    localparam int unsigned c_drop_w = c_cnt_w + 4;

    fetch_state_t        r_state;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_rsp_pc;
    logic [c_cnt_w-1:0]  r_outstanding;
    logic [c_drop_w-1:0] r_drop_cnt;

    logic [c_cnt_w-1:0]  w_count;
    fetch_entry_t        w_head;
    fetch_entry_t        w_push_data;
    logic                w_credit;
    logic                w_req_fire;
    logic                w_rsp_drop;
    logic                w_push;
    logic                w_pop;
    logic                w_rsp_owed;
    logic [c_drop_w-1:0] w_inflight;
    logic [c_drop_w-1:0] w_drop_next;
    logic [31:0]         w_redirect_pc;
    logic                w_unused_bits;

    assign w_credit       = ({1'b0, w_count} + {1'b0, r_outstanding}) < c_sum_w'(DEPTH);
    assign imem_req_valid = (r_state != ST_RESET_WAIT) && w_credit && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop     = imem_rsp_valid && (redirect_valid || (r_drop_cnt != '0));
    assign w_push         = imem_rsp_valid && !w_rsp_drop;
    assign w_pop          = instr_valid && instr_ready;

    assign instr_valid    = (w_count != '0);
    assign instr          = instr_valid ? w_head.instr : NOP_INSTR;
    assign instr_pc       = instr_valid ? w_head.pc : 32'h0;

    assign w_push_data    = '{instr: imem_rsp_data, pc: r_rsp_pc};
    assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits  = ^redirect_pc[1:0];

    // Everything memory still owes us; a response landing this cycle retires one.
    assign w_inflight  = r_drop_cnt + c_drop_w'(r_outstanding) + c_drop_w'(w_req_fire);
    assign w_rsp_owed  = imem_rsp_valid && (w_inflight != '0);
    assign w_drop_next = redirect_valid ? (w_inflight - c_drop_w'(w_rsp_owed))
                                        : (r_drop_cnt - c_drop_w'(w_rsp_drop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RESET_WAIT;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc    <= w_redirect_pc;
                r_rsp_pc      <= w_redirect_pc;
                r_outstanding <= '0;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
                r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_push);
            end
            r_drop_cnt <= w_drop_next;

            case (r_state)
                ST_RESET_WAIT: r_state <= ST_FETCH;
                ST_FETCH,
                ST_DRAIN:      r_state <= (w_drop_next != '0) ? ST_DRAIN : ST_FETCH;
                default:       r_state <= ST_FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_unit
// Brief    : Directed bench with an in-order latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_instr[$];
    int          dl_cyc[$];

    if_prefetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) ^ a ^ 32'hA5C3_0F13;
    endfunction

    // Memory: answers in order, lat cycles after acceptance; forgets everything on reset.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back({imem_req_addr, cyc + lat});
                acc_log.push_back(imem_req_addr);
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (rst_n && instr_valid && instr_ready) begin
            dl_pc.push_back(instr_pc);
            dl_instr.push_back(instr);
            dl_cyc.push_back(cyc);
        end
    end

    task automatic clear_logs();
        acc_log.delete();
        dl_pc.delete();
        dl_instr.delete();
        dl_cyc.delete();
    endtask

    task automatic do_reset(input logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = rdy;
        imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        clear_logs();
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #4;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
        vectors++; if (instr !== NOP_INSTR) begin miscompares++; $display("FAIL rst_instr got %h want %h", instr, NOP_INSTR); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
        do_reset(1'b0);
        @(negedge clk); #4;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wait_req got %b want 0", imem_req_valid); end
        @(negedge clk); #4;
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL first_req_valid got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL first_req_addr got %h want 0", imem_req_addr); end
    endtask

    task automatic test_stream();
        lat = 1;
        do_reset(1'b1);
        repeat (18) @(negedge clk); #4;
        vectors++; if (dl_pc.size() < 12) begin miscompares++; $display("FAIL stream_count got %0d want >=12", dl_pc.size()); end
        for (int i = 0; i < 12 && i < dl_pc.size(); i++) begin
            vectors++; if (dl_pc[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_pc[%0d] got %h want %h", i, dl_pc[i], 32'(i * 4)); end
            vectors++; if (dl_instr[i] !== mem_word(32'(i * 4))) begin miscompares++; $display("FAIL stream_instr[%0d] got %h want %h", i, dl_instr[i], mem_word(32'(i * 4))); end
            vectors++; if (dl_cyc[i] !== dl_cyc[0] + i) begin miscompares++; $display("FAIL stream_rate[%0d] got cycle %0d want %0d", i, dl_cyc[i], dl_cyc[0] + i); end
            vectors++; if (acc_log[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_req_addr[%0d] got %h want %h", i, acc_log[i], 32'(i * 4)); end
        end
    endtask

    task automatic test_backpressure();
        lat = 1;
        do_reset(1'b0);
        repeat (12) @(negedge clk); #4;
        vectors++; if (acc_log.size() != 4) begin miscompares++; $display("FAIL bp_req_count got %0d want 4", acc_log.size()); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid got %b want 0", imem_req_valid); end
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL bp_instr_valid got %b want 1", instr_valid); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head_pc got %h want 0", instr_pc); end
        vectors++; if (instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL bp_head_instr got %h want %h", instr, mem_word(32'h0)); end
        @(negedge clk);
        instr_ready = 1'b1;
        repeat (16) @(negedge clk); #4;
        vectors++; if (dl_pc.size() < 10) begin miscompares++; $display("FAIL bp_resume_count got %0d want >=10", dl_pc.size()); end
        for (int i = 0; i < 10 && i < dl_pc.size(); i++) begin
            vectors++; if (dl_pc[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL bp_pc[%0d] got %h want %h", i, dl_pc[i], 32'(i * 4)); end
            vectors++; if (dl_instr[i] !== mem_word(32'(i * 4))) begin miscompares++; $display("FAIL bp_instr[%0d] got %h want %h", i, dl_instr[i], mem_word(32'(i * 4))); end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc;
        lat = 2;
        do_reset(1'b1);
        repeat (10) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #4;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_req_blocked got %b want 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        clear_logs();
        #4;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush_valid got %b want 0", instr_valid); end
        vectors++; if (instr !== NOP_INSTR) begin miscompares++; $display("FAIL redir_flush_instr got %h want %h", instr, NOP_INSTR); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL redir_flush_pc got %h want 0", instr_pc); end
        vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL redir_req_addr got %h want 100", imem_req_addr); end
        repeat (14) @(negedge clk); #4;
        vectors++; if (dl_pc.size() < 8) begin miscompares++; $display("FAIL redir_count got %0d want >=8", dl_pc.size()); end
        for (int i = 0; i < 8 && i < dl_pc.size(); i++) begin
            exp_pc = 32'h100 + 32'(i * 4);
            vectors++; if (dl_pc[i] !== exp_pc) begin miscompares++; $display("FAIL redir_pc[%0d] got %h want %h", i, dl_pc[i], exp_pc); end
            vectors++; if (dl_instr[i] !== mem_word(exp_pc)) begin miscompares++; $display("FAIL redir_instr[%0d] got %h want %h", i, dl_instr[i], mem_word(exp_pc)); end
        end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
        lat = 1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        clear_logs();
        #4;
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL align_req_valid got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL align_req_addr got %h want 200", imem_req_addr); end
        repeat (10) @(negedge clk); #4;
        vectors++; if (dl_pc.size() < 4) begin miscompares++; $display("FAIL align_count got %0d want >=4", dl_pc.size()); end
        for (int i = 0; i < 4 && i < dl_pc.size(); i++) begin
            exp_pc = 32'h200 + 32'(i * 4);
            vectors++; if (dl_pc[i] !== exp_pc) begin miscompares++; $display("FAIL align_pc[%0d] got %h want %h", i, dl_pc[i], exp_pc); end
            vectors++; if (dl_instr[i] !== mem_word(exp_pc)) begin miscompares++; $display("FAIL align_instr[%0d] got %h want %h", i, dl_instr[i], mem_word(exp_pc)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        for (int gap = 0; gap < 2; gap++) begin
            lat = 3;
            do_reset(1'b1);
            repeat (8) @(negedge clk);
            @(negedge clk);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h40;
            if (gap == 1) begin
                @(negedge clk);
                redirect_valid = 1'b0;
            end
            @(negedge clk);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h80;
            @(negedge clk);
            redirect_valid = 1'b0;
            clear_logs();
            repeat (24) @(negedge clk); #4;
            vectors++; if (dl_pc.size() < 10) begin miscompares++; $display("FAIL b2b_count gap=%0d got %0d want >=10", gap, dl_pc.size()); end
            for (int i = 0; i < dl_pc.size(); i++) begin
                exp_pc = 32'h80 + 32'(i * 4);
                vectors++; if (dl_pc[i] !== exp_pc) begin miscompares++; $display("FAIL b2b_pc gap=%0d [%0d] got %h want %h", gap, i, dl_pc[i], exp_pc); end
                vectors++; if (dl_instr[i] !== mem_word(exp_pc)) begin miscompares++; $display("FAIL b2b_instr gap=%0d [%0d] got %h want %h", gap, i, dl_instr[i], mem_word(exp_pc)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        lat = 1;
        do_reset(1'b1);
        repeat (6) @(negedge clk);
        instr_ready = 1'b0;
        repeat (10) @(negedge clk); #4;
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_full got %b want 1", instr_valid); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_req got %b want 0", imem_req_valid); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", instr_valid); end
        vectors++; if (instr !== NOP_INSTR) begin miscompares++; $display("FAIL mid_rst_instr got %h want %h", instr, NOP_INSTR); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL mid_rst_pc got %h want 0", instr_pc); end
        do_reset(1'b1);
        @(negedge clk); #4;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mid_wait_req got %b want 0", imem_req_valid); end
        @(negedge clk); #4;
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL mid_restart_valid got %b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart_addr got %h want 0", imem_req_addr); end
        repeat (10) @(negedge clk); #4;
        vectors++; if (dl_pc.size() < 5) begin miscompares++; $display("FAIL mid_count got %0d want >=5", dl_pc.size()); end
        for (int i = 0; i < 5 && i < dl_pc.size(); i++) begin
            vectors++; if (dl_pc[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL mid_pc[%0d] got %h want %h", i, dl_pc[i], 32'(i * 4)); end
            vectors++; if (dl_instr[i] !== mem_word(32'(i * 4))) begin miscompares++; $display("FAIL mid_instr[%0d] got %h want %h", i, dl_instr[i], mem_word(32'(i * 4))); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_align();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
